// File: rtl/sseg_mux_disp.sv
// sseg_mux_disp
//   Drives three BCD digits onto one common-anode seven-segment bus.
//   The digits are shown one after another, one per time slot.
//   A snapshot of d2/d1/d0 is taken once per frame, so a frame never shows a mix
//   of old and new digits.
//   Extra display features:
//     - a guard interval with all anodes off at the start of every slot (anti-ghosting);
//     - optional leading-zero blanking;
//     - live per-digit decimal points.
//
// Parameters
//   REFRESH_DIV  clocks per digit slot (>= 2)
//   BLANK_CYC    guard clocks at the start of each slot with all anodes off (< REFRESH_DIV)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   d2,d1,d0    BCD digits; d2 is the most significant
//   dp_pos      decimal point enable per digit, active high, sampled live
//   lzb         1 = suppress leading zeros on d2/d1
//   an          anode enables, active low, bit i = digit i
//   sseg        segments, active low, [7]=dp, [6:0]=g..a
//   frame_tick  one-clock pulse in the first cycle of each frame (not the first frame)
//
// Slot sequencer (idx_q)
//   state | meaning
//   SLOT0 | digit 0 (least significant) owns the bus
//   SLOT1 | digit 1 owns the bus
//   SLOT2 | digit 2 owns the bus; snapshot is loaded on its last cycle

module sseg_mux_disp #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [2:0] dp_pos,
    input  logic       lzb,
    output logic [2:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    localparam logic [1:0] SLOT0 = 2'd0;
    localparam logic [1:0] SLOT1 = 2'd1;
    localparam logic [1:0] SLOT2 = 2'd2;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [11:0]      snap_q, snap_d;
    logic [2:0]       an_q, an_d;
    logic [7:0]       sseg_q, sseg_d;
    logic             frame_tick_q, frame_tick_d;

    logic             cnt_wrap;
    logic [3:0]       digit_val;
    logic             digit_dp;
    logic             digit_blank;
    logic             blank2;
    logic             blank1;
    logic [6:0]       seg7;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= SLOT0;
            snap_q       <= '0;
            an_q         <= 3'b111;
            sseg_q       <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Next-state: prescaler, slot sequencer, snapshot
    always_comb begin
        cnt_wrap     = (cnt_q == CNT_LAST);
        cnt_d        = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        snap_d       = snap_q;
        frame_tick_d = 1'b0;
        if (cnt_wrap) begin
            case (idx_q)
                SLOT0:   idx_d = SLOT1;
                SLOT1:   idx_d = SLOT2;
                default: idx_d = SLOT0;
            endcase
            if (idx_q == SLOT2) begin
                // Frame boundary: latch the next frame's digits.
                // The tick flop then goes high together with cnt=0/idx=0.
                snap_d       = {d2, d1, d0};
                frame_tick_d = 1'b1;
            end
        end
    end

    // Output: select, blank and decode the digit owning the current slot.
    // The result is registered, so the pins lag cnt/idx by one clock.
    always_comb begin
        blank2 = lzb && (snap_q[11:8] == 4'd0);
        blank1 = blank2 && (snap_q[7:4] == 4'd0);

        digit_val   = snap_q[3:0];
        digit_dp    = dp_pos[0];
        digit_blank = 1'b0;
        case (idx_q)
            SLOT1: begin
                digit_val   = snap_q[7:4];
                digit_dp    = dp_pos[1];
                digit_blank = blank1;
            end
            SLOT2: begin
                digit_val   = snap_q[11:8];
                digit_dp    = dp_pos[2];
                digit_blank = blank2;
            end
            default: begin
                digit_val   = snap_q[3:0];
                digit_dp    = dp_pos[0];
                digit_blank = 1'b0;
            end
        endcase

        case (digit_val)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b0111111;   // invalid BCD shows '-'
        endcase

        // The guard interval and blanked digits both leave the bus fully dark.
        // A blanked digit also loses its decimal point.
        if ((cnt_q < CNT_BLANK) || digit_blank || (idx_q == 2'd3)) begin
            an_d   = 3'b111;
            sseg_d = 8'hFF;
        end else begin
            an_d   = ~(3'b001 << idx_q);
            sseg_d = {~digit_dp, seg7};
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_mux_disp.sv
// Directed bench for sseg_mux_disp with REFRESH_DIV=8 and BLANK_CYC=2.
// Cycle c is sampled just before rising edge c after reset release.
// A frame is 24 cycles, and frame f starts at cycle 24*f.
// Digit i of frame f shows non-dark values in cycles 24f+8i+3 .. 24f+8i+8.
// The snapshot for frame f is taken on edge 24f-1.

module tb_sseg_mux_disp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d2, d1, d0;
    logic [2:0] dp_pos;
    logic       lzb;
    logic [2:0] an;
    logic [7:0] sseg;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    sseg_mux_disp #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d2         (d2),
        .d1         (d1),
        .d0         (d0),
        .dp_pos     (dp_pos),
        .lzb        (lzb),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic chk(input string tag, input logic [2:0] ea, input logic [7:0] es);
        checks++;
        assert ({an, sseg} === {ea, es}) else begin
            errors++;
            $error("FAIL %s (cyc %0d): observed an=%b sseg=%h expected an=%b sseg=%h",
                   tag, cyc, an, sseg, ea, es);
        end
    endtask

    task automatic chk_ft(input string tag, input logic e);
        checks++;
        assert (frame_tick === e) else begin
            errors++;
            $error("FAIL %s (cyc %0d): observed frame_tick=%b expected %b", tag, cyc, frame_tick, e);
        end
    endtask

    // Checks one digit slot of frame f:
    //   - guard cycle (dark);
    //   - first displayed cycle;
    //   - a later displayed cycle.
    task automatic digit(input int f, input int i, input logic [2:0] ea,
                         input logic [7:0] es, input string tag);
        run_to(24*f + 8*i + 1);
        chk({tag, "_guard"}, 3'b111, 8'hFF);
        run_to(24*f + 8*i + 3);
        chk({tag, "_first"}, ea, es);
        run_to(24*f + 8*i + 7);
        chk({tag, "_late"}, ea, es);
    endtask

    initial begin
        rst_n  = 1'b0;
        d2     = 4'd0;
        d1     = 4'd0;
        d0     = 4'd0;
        dp_pos = 3'b000;
        lzb    = 1'b0;

        // Scenario 1: reset and first slots
        repeat (3) @(negedge clk);
        chk("rst_hold", 3'b111, 8'hFF);
        chk_ft("rst_hold_ft", 1'b0);
        rst_n = 1'b1;
        cyc   = 0;
        chk("s1_c0", 3'b111, 8'hFF);
        chk_ft("s1_c0_ft", 1'b0);
        run_to(2);  chk("s1_c2", 3'b111, 8'hFF);
        run_to(3);  chk("s1_c3", 3'b110, 8'hC0);
        run_to(8);  chk("s1_c8", 3'b110, 8'hC0);
        run_to(9);  chk("s1_c9", 3'b111, 8'hFF);
        run_to(10); chk("s1_c10", 3'b111, 8'hFF);
        run_to(11); chk("s1_c11", 3'b101, 8'hC0);

        // Scenario 2: mid-frame input change takes effect only at the next frame
        run_to(12);
        d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
        run_to(19); chk("s2_nochange", 3'b011, 8'hC0);
        run_to(23); chk_ft("s2_ft_before", 1'b0);
        run_to(24); chk_ft("s2_ft", 1'b1);
        run_to(25); chk_ft("s2_ft_after", 1'b0);
        digit(1, 0, 3'b110, 8'hB0, "s2_d0");
        run_to(32);
        d2 = 4'd9; d1 = 4'd9; d0 = 4'd9;   // must not show during frame 1
        digit(1, 1, 3'b101, 8'hA4, "s2_d1");
        digit(1, 2, 3'b011, 8'hF9, "s2_d2");

        // Scenario 3: leading-zero blanking
        lzb = 1'b1; d2 = 4'd0; d1 = 4'd0; d0 = 4'd7;
        digit(2, 0, 3'b110, 8'hF8, "s3a_d0");
        digit(2, 1, 3'b111, 8'hFF, "s3a_d1");
        digit(2, 2, 3'b111, 8'hFF, "s3a_d2");
        d0 = 4'd0;
        digit(3, 0, 3'b110, 8'hC0, "s3b_d0");
        digit(3, 1, 3'b111, 8'hFF, "s3b_d1");
        digit(3, 2, 3'b111, 8'hFF, "s3b_d2");
        d1 = 4'd5;
        digit(4, 0, 3'b110, 8'hC0, "s3c_d0");
        digit(4, 1, 3'b101, 8'h92, "s3c_d1");
        digit(4, 2, 3'b111, 8'hFF, "s3c_d2");

        // Scenario 4: invalid BCD codes 10..15 show '-'
        for (int code = 10; code <= 15; code++) begin
            run_to(24*(code - 5) - 1);
            d2 = 4'd0; d1 = 4'd0; d0 = 4'(code);
            digit(code - 5, 0, 3'b110, 8'hBF, $sformatf("s4_code%0d", code));
        end

        // Scenario 5: decimal points
        run_to(263);
        lzb = 1'b0; d2 = 4'd1; d1 = 4'd5; d0 = 4'd2; dp_pos = 3'b010;
        digit(11, 0, 3'b110, 8'hA4, "s5_d0");
        digit(11, 1, 3'b101, 8'h12, "s5_d1");
        digit(11, 2, 3'b011, 8'hF9, "s5_d2");
        // A blanked digit loses its decimal point.
        lzb = 1'b1; d2 = 4'd0; d1 = 4'd0; d0 = 4'd4; dp_pos = 3'b111;
        digit(12, 0, 3'b110, 8'h19, "s5b_d0");
        digit(12, 1, 3'b111, 8'hFF, "s5b_d1");
        digit(12, 2, 3'b111, 8'hFF, "s5b_d2");

        // Scenario 6: asynchronous reset in slot 1 at cnt=5
        lzb = 1'b0; dp_pos = 3'b000; d2 = 4'd9; d1 = 4'd8; d0 = 4'd7;
        digit(13, 0, 3'b110, 8'hF8, "s6_pre_d0");
        run_to(325); chk("s6_pre_d1", 3'b101, 8'h80);
        rst_n = 1'b0;
        #1;
        chk("s6_async", 3'b111, 8'hFF);
        chk_ft("s6_async_ft", 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        chk("s6_c0", 3'b111, 8'hFF);
        run_to(2);  chk("s6_c2", 3'b111, 8'hFF);
        run_to(3);  chk("s6_c3", 3'b110, 8'hC0);
        run_to(9);  chk("s6_c9", 3'b111, 8'hFF);
        run_to(11); chk("s6_c11", 3'b101, 8'hC0);
        run_to(19); chk("s6_c19", 3'b011, 8'hC0);
        run_to(24); chk_ft("s6_ft", 1'b1);
        digit(1, 0, 3'b110, 8'hF8, "s6_f1_d0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
